// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer.
//   TICK_HZ        rate of the shared prescaler tick (1 ms period)
//   db_state_t     per-channel filter state
//   prescale_max   terminal count of the prescaler for a given clock frequency
//   cnt_width      register width able to hold 0..max_val (never below 1)
package debounce_pkg;

  localparam int unsigned TICK_HZ = 1000;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_t;

  function automatic int unsigned prescale_max(input int unsigned frq);
    return (frq / TICK_HZ) - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) <= 64'(max_val)) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: two-flop synchroniser, STABLE/SETTLING filter and a
// tick counter. dout only takes a new level after the synchronised input has
// differed from it for TIME_MS consecutive ticks.
// Ports:
//   CLK    in   system clock
//   RESET  in   asynchronous, active-high reset
//   din    in   raw asynchronous level
//   tick   in   1 ms strobe from the shared prescaler
//   dout   out  debounced level (registered)
//   upd    out  combinational: dout takes a new value on the next CLK edge
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned TIME_MS = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic din,
  input  logic tick,
  output logic dout,
  output logic upd
);

  logic meta;
  logic sync;

  // Plain two-flop synchroniser, nothing between the stages.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  if (TIME_MS == 0) begin : g_nofilt
    // No filtering: follow the synchronised level every cycle.
    logic unused_tick;
    assign unused_tick = tick;
    assign upd         = sync ^ dout;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        dout <= 1'b0;
      end else begin
        dout <= sync;
      end
    end
  end else begin : g_filt
    localparam int unsigned   CW       = cnt_width(TIME_MS);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIME_MS - 1);

    db_state_t     state;
    logic [CW-1:0] count;
    logic          differs;
    logic          accept;

    assign differs = (sync != dout);
    // The tick that completes the count updates dout in the same cycle, so a
    // stored count of TIME_MS-1 plus this tick equals TIME_MS ticks.
    assign accept  = (state == DB_SETTLING) && differs && tick && (count == CNT_LAST);
    assign upd     = accept;

    // Filter FSM; a bounce back to the current level wins over a tick.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        state <= DB_STABLE;
        count <= '0;
        dout  <= 1'b0;
      end else begin
        case (state)
          DB_STABLE: begin
            if (differs) begin
              state <= DB_SETTLING;
              count <= '0;
            end
          end
          DB_SETTLING: begin
            if (!differs) begin
              state <= DB_STABLE;
              count <= '0;
            end else if (accept) begin
              dout  <= sync;
              state <= DB_STABLE;
              count <= '0;
            end else if (tick) begin
              count <= count + CW'(1);
            end
          end
          default: begin
            state <= DB_STABLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Multi-bit switch/button debouncer. Each DIN bit is synchronised and only
// accepted once stable for TIME_MS milliseconds; CHANGED pulses for one cycle
// whenever DOUT takes a new value.
// Optional build macro INPUT_DEBOUNCER_EDGE_EN adds ROSE/FELL per-bit pulses.
// Ports:
//   CLK      in   system clock
//   RESET    in   asynchronous, active-high reset
//   DIN      in   [BITS] raw switch levels
//   DOUT     out  [BITS] debounced levels (registered)
//   CHANGED  out  one-cycle strobe aligned with any DOUT update
//   ROSE     out  [BITS] 0->1 update pulse (INPUT_DEBOUNCER_EDGE_EN only)
//   FELL     out  [BITS] 1->0 update pulse (INPUT_DEBOUNCER_EDGE_EN only)
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned FRQ     = 50000000,
  parameter int unsigned TIME_MS = 1,
  parameter int unsigned BITS    = 10
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [BITS-1:0] DIN,
  output logic [BITS-1:0] DOUT,
  output logic            CHANGED
`ifdef INPUT_DEBOUNCER_EDGE_EN
  ,
  output logic [BITS-1:0] ROSE,
  output logic [BITS-1:0] FELL
`endif
);

  localparam int unsigned PRE_MAX = prescale_max(FRQ);
  localparam int unsigned PW      = cnt_width(PRE_MAX);

  logic [PW-1:0]   pre;
  logic            tick;
  logic [BITS-1:0] dbit;
  logic [BITS-1:0] upd;

  assign tick = (pre == PW'(PRE_MAX));

  // Free-running 1 ms prescaler shared by all channels.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar g = 0; g < int'(BITS); g++) begin : g_ch
    debounce_bit #(
      .TIME_MS (TIME_MS)
    ) u_bit (
      .CLK   (CLK),
      .RESET (RESET),
      .din   (DIN[g]),
      .tick  (tick),
      .dout  (dbit[g]),
      .upd   (upd[g])
    );
  end

  assign DOUT = dbit;

  // Registered on the same edge that updates DOUT, so the strobe lines up.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CHANGED <= 1'b0;
    end else begin
      CHANGED <= |upd;
    end
  end

`ifdef INPUT_DEBOUNCER_EDGE_EN
  // Direction follows the old level: an update from 0 is a rise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ROSE <= '0;
      FELL <= '0;
    end else begin
      ROSE <= upd & ~dbit;
      FELL <= upd & dbit;
    end
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (FRQ=10000 -> tick every 10 cycles,
// TIME_MS=3, BITS=4). A reference model pushes expected DOUT updates into a
// queue; an independent monitor pops them when CHANGED is seen.
module tb_input_debouncer;

  localparam int unsigned FRQ     = 10000;
  localparam int unsigned TIME_MS = 3;
  localparam int unsigned BITS    = 4;
  localparam int          TICKC   = FRQ / 1000;

  logic            CLK;
  logic            RESET;
  logic [BITS-1:0] DIN;
  logic [BITS-1:0] DOUT;
  logic            CHANGED;
`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic [BITS-1:0] ROSE;
  logic [BITS-1:0] FELL;
`endif

  input_debouncer #(
    .FRQ     (FRQ),
    .TIME_MS (TIME_MS),
    .BITS    (BITS)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .CHANGED (CHANGED)
`ifdef INPUT_DEBOUNCER_EDGE_EN
    ,
    .ROSE    (ROSE),
    .FELL    (FELL)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic [BITS-1:0] last_rose = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // DOUT[i] adopts the synchronised level s once s has differed from DOUT
  // without interruption from edge `start` and TIME_MS tick edges (every
  // TICKC-th edge after reset) have occurred strictly after `start`.
  typedef struct {
    int              n;
    logic [BITS-1:0] dout;
    logic [BITS-1:0] rose;
    logic [BITS-1:0] fell;
  } ev_t;

  ev_t             exp_q[$];
  int              n;
  logic [BITS-1:0] d1, d2, mdout;
  int              start[BITS];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      n     = 0;
      d1    = '0;
      d2    = '0;
      mdout = '0;
      for (int i = 0; i < int'(BITS); i++) start[i] = -1;
      exp_q.delete();
    end else begin
      logic [BITS-1:0] nd;
      n++;
      nd = mdout;
      for (int i = 0; i < int'(BITS); i++) begin
        if (d2[i] == mdout[i]) start[i] = -1;
        else if (start[i] < 0) start[i] = n;
        else if ((n / TICKC) - (start[i] / TICKC) == int'(TIME_MS)) begin
          nd[i]    = d2[i];
          start[i] = -1;
        end
      end
      if (nd != mdout) begin
        ev_t e;
        e.n    = n;
        e.dout = nd;
        e.rose = nd & ~mdout;
        e.fell = ~nd & mdout;
        exp_q.push_back(e);
      end
      mdout = nd;
      d2    = d1;
      d1    = DIN;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (RESET) begin
      chk("reset_dout", 32'(DOUT), 32'(0));
      chk("reset_changed", 32'(CHANGED), 32'(0));
    end else begin
      chk("dout_vs_model", 32'(DOUT), 32'(mdout));
      if (CHANGED) begin
        pulses++;
`ifdef INPUT_DEBOUNCER_EDGE_EN
        last_rose = ROSE;
`endif
        if (exp_q.size() == 0) begin
          chk("spurious_changed", 32'(CHANGED), 32'(0));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("changed_cycle", 32'(n), 32'(e.n));
          chk("changed_dout", 32'(DOUT), 32'(e.dout));
`ifdef INPUT_DEBOUNCER_EDGE_EN
          chk("rose", 32'(ROSE), 32'(e.rose));
          chk("fell", 32'(FELL), 32'(e.fell));
`endif
        end
      end else if (exp_q.size() > 0 && exp_q[0].n <= n) begin
        chk("missed_changed", 32'(CHANGED), 32'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic wait_dout(input logic [BITS-1:0] mask, input logic [BITS-1:0] val,
                           input int max, output int lat);
    lat = max + 1;
    for (int k = 1; k <= max; k++) begin
      @(negedge CLK);
      if ((DOUT & mask) == val) begin
        lat = k;
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lat;
    int p0;
    logic moved;

    // 1: reset with all inputs high
    RESET = 1'b1;
    DIN   = 4'hF;
    step(3);
    @(negedge CLK);
    chk("t1_dout_in_reset", 32'(DOUT), 32'(0));
    chk("t1_changed_in_reset", 32'(CHANGED), 32'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    p0 = pulses;
    wait_dout(4'hF, 4'hF, 40, lat);
    chk_range("t1_release_latency", lat, 1, 32);
    step(2);
    chk("t1_pulses", 32'(pulses - p0), 32'(1));

    // 2: clean edge on bit 0
    DIN = 4'h0;
    wait_dout(4'hF, 4'h0, 40, lat);
    step(3);
    p0 = pulses;
    DIN[0] = 1'b1;
    wait_dout(4'h1, 4'h1, 40, lat);
    chk_range("t2_clean_latency", lat, 23, 33);
    step(2);
    chk("t2_pulses", 32'(pulses - p0), 32'(1));
`ifdef INPUT_DEBOUNCER_EDGE_EN
    chk("t2_rose", 32'(last_rose), 32'(4'b0001));
`endif

    // 3: bounce on bit 1 every 7 cycles, then hold high
    moved = 1'b0;
    for (int t = 0; t < 14; t++) begin
      DIN[1] = ~DIN[1];
      for (int c = 0; c < 7; c++) begin
        @(negedge CLK);
        if (DOUT[1]) moved = 1'b1;
      end
      @(posedge CLK); #1;
    end
    chk("t3_no_change_while_bouncing", 32'(moved), 32'(0));
    DIN[1] = 1'b1;
    wait_dout(4'h2, 4'h2, 40, lat);
    chk_range("t3_bounce_latency", lat, 23, 33);

    // 4: one-cycle glitch on bit 2
    step(3);
    p0 = pulses;
    DIN[2] = 1'b1;
    step(1);
    DIN[2] = 1'b0;
    step(40);
    chk("t4_glitch_pulses", 32'(pulses - p0), 32'(0));
    chk("t4_glitch_dout", 32'(DOUT), 32'(4'b0011));

    // 5: two bits rising together
    DIN = 4'h0;
    wait_dout(4'hF, 4'h0, 40, lat);
    step(3);
    p0 = pulses;
    DIN = 4'b1010;
    wait_dout(4'hF, 4'b1010, 40, lat);
    chk_range("t5_simul_latency", lat, 23, 33);
    step(2);
    chk("t5_single_pulse", 32'(pulses - p0), 32'(1));
`ifdef INPUT_DEBOUNCER_EDGE_EN
    chk("t5_rose", 32'(last_rose), 32'(4'b1010));
`endif

    // 6: reset in the middle of settling
    DIN = 4'h0;
    wait_dout(4'hF, 4'h0, 40, lat);
    step(3);
    DIN = 4'b1000;
    step(15);
    RESET = 1'b1;
    @(negedge CLK);
    chk("t6_dout_in_reset", 32'(DOUT), 32'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    wait_dout(4'h8, 4'h8, 40, lat);
    chk_range("t6_post_reset_latency", lat, 23, 33);

    // 7: randomized traffic checked by the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          DIN = 4'($urandom);
          step(int'($urandom_range(25, 45)));
        end
        1: begin
          int b;
          b = int'($urandom_range(0, 3));
          DIN[b] = ~DIN[b];
          step(int'($urandom_range(1, 8)));
          DIN[b] = ~DIN[b];
          step(5);
        end
        2: begin
          int b;
          int per;
          b   = int'($urandom_range(0, 3));
          per = int'($urandom_range(2, 9));
          for (int k = 0; k < 5; k++) begin
            DIN[b] = ~DIN[b];
            step(per);
          end
        end
        default: step(35);
      endcase
    end
    step(40);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
